uart_tx_drain: RTL and testbench
================================

UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 Parameter CLK_DIV, default 16: clock cycles per UART bit, legal range 2..65535.
REQ-002 Parameter DATA_WIDTH, default 8: bits per frame payload, sent LSB first.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset is synchronous and active-high.
REQ-005 Port fifoEmpty, input, 1 bit: source FIFO holds no words.
REQ-006 Port fifoReadReq, output, 1 bit: pop request to the source FIFO.
REQ-007 Port fifoReadAck, input, 1 bit: FIFO accepted the pop; fifoData valid in the same cycle.
REQ-008 Port fifoData, input, DATA_WIDTH bits: word returned by the FIFO.
REQ-009 Port tx, output, 1 bit: serial line, idle high.
REQ-010 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 The block SHALL implement the states IDLE, REQ, WAIT_ACK, START, DATA and STOP.
REQ-012 IDLE: tx=1; when fifoEmpty=0, the next state SHALL be REQ, otherwise the block stays in IDLE.
REQ-013 REQ: fifoReadReq=1 for exactly this one cycle; the next state SHALL be WAIT_ACK unconditionally.
REQ-014 fifoReadReq SHALL be registered and SHALL never be high for two consecutive cycles, so that one request pops at most one word.
REQ-015 WAIT_ACK: if fifoReadAck=1, the block SHALL latch fifoData into the shift register, clear the bit-timer, and go to START; otherwise it SHALL return to IDLE with nothing sent.
REQ-016 fifoReadAck and fifoData SHALL be ignored in every state other than WAIT_ACK.
REQ-017 START: tx=0 for exactly CLK_DIV cycles, then the block SHALL go to DATA with bit index 0.
REQ-018 DATA: tx=shift[0] for CLK_DIV cycles per bit, then the block SHALL shift right; after bit index DATA_WIDTH-1 completes, the next state SHALL be STOP.
REQ-019 STOP: tx=1 for exactly CLK_DIV cycles, then the block SHALL go to IDLE.
REQ-020 tx SHALL be driven from a register, so there are no combinational glitches on the line.
REQ-021 The bit-timer SHALL be wide enough to count to CLK_DIV-1, reload to 0 at each bit boundary, and never wrap mid-bit.
REQ-022 Frame length SHALL be exactly (DATA_WIDTH+2)*CLK_DIV cycles, measured from the first tx=0 cycle to the last stop-bit cycle inclusive.
REQ-023 Back-to-back frames: the line gap between the end of STOP and the next start bit SHALL be exactly 3 cycles (IDLE, REQ, WAIT_ACK), during which tx=1.
REQ-024 Latency: fifoReadReq high in cycle N with fifoReadAck high in N+1 SHALL give tx=0 first in cycle N+2.
REQ-025 A change of fifoEmpty during a frame SHALL have no effect until the block re-enters IDLE.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL enter IDLE regardless of its current state, including mid-frame.
REQ-027 After reset, tx=1, fifoReadReq=0, busy=0, the bit-timer, bit index and shift register SHALL all be 0, and no partial frame is resumed.
REQ-028 rst SHALL take precedence over every other input in the same cycle, including fifoReadAck.

Verification (CLK_DIV=4, DATA_WIDTH=8)
REQ-029 FIFO holds 0x55 -> fifoReadReq pulses once; tx = 0 then 1,0,1,0,1,0,1,0 then 1, each bit for 4 cycles (40 cycles total); busy high throughout; fifoReadReq=0 afterwards.
REQ-030 FIFO holds 0x00 then 0xFF, with fifoEmpty=0 between the two -> two frames separated by a 3-cycle high gap; second payload is 8 bits of 1 for 32 cycles; exactly two read pulses.
REQ-031 fifoReadAck=0 in WAIT_ACK (FIFO emptied) -> tx stays 1, block returns to IDLE, then retries REQ only while fifoEmpty=0.
REQ-032 rst asserted in DATA at bit 3 of 0xA5 -> next cycle tx=1, busy=0, fifoReadReq=0; after release with fifoEmpty=0, a fresh complete frame is sent.
REQ-033 fifoReadAck forced high in IDLE, START, DATA and STOP -> no state, data or tx change.
REQ-034 fifoEmpty=1 held for 100 cycles after reset -> tx=1, busy=0, fifoReadReq never asserted.

Source files
------------

// File: rtl/uart_tx_drain_if.sv
// Read-side handshake between uart_tx_drain and its source FIFO.
// The drain is the master: it issues pops and consumes the returned word.
interface uart_tx_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifoEmpty;
    logic                  fifoReadReq;
    logic                  fifoReadAck;
    logic [DATA_WIDTH-1:0] fifoData;

    modport master (
        input  fifoEmpty,
        input  fifoReadAck,
        input  fifoData,
        output fifoReadReq
    );

    modport slave (
        output fifoEmpty,
        output fifoReadAck,
        output fifoData,
        input  fifoReadReq
    );
endinterface

// File: rtl/uart_tx_drain.sv
// UART transmitter that pulls words from a FIFO one pop at a time and sends
// each as start bit, DATA_WIDTH data bits LSB first and one stop bit.
module uart_tx_drain #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_drain_if.master fifo,
    output logic            tx,
    output logic            busy
);
    localparam int TIMER_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state;
    logic [TIMER_W-1:0]    bitTimer;
    logic [IDX_W-1:0]      bitIdx;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic [DATA_WIDTH-1:0] shiftNext;
    logic                  bitDone;
    logic                  readReq;

    assign shiftNext        = shiftReg >> 1;
    assign bitDone          = (bitTimer == TIMER_LAST);
    assign fifo.fifoReadReq = readReq;

    // tx, busy and readReq are all registered and updated on the transition
    // into the state that owns them, so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            readReq  <= 1'b0;
            bitTimer <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
        end else begin
            readReq <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!fifo.fifoEmpty) begin
                        state   <= REQ;
                        readReq <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                REQ: begin
                    state <= WAIT_ACK;
                end

                WAIT_ACK: begin
                    if (fifo.fifoReadAck) begin
                        shiftReg <= fifo.fifoData;
                        bitTimer <= '0;
                        bitIdx   <= '0;
                        tx       <= 1'b0;
                        state    <= START;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                START: begin
                    if (bitDone) begin
                        bitTimer <= '0;
                        bitIdx   <= '0;
                        tx       <= shiftReg[0];
                        state    <= DATA;
                    end else begin
                        bitTimer <= bitTimer + TIMER_W'(1);
                    end
                end

                DATA: begin
                    if (bitDone) begin
                        bitTimer <= '0;
                        if (bitIdx == IDX_LAST) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bitIdx   <= bitIdx + IDX_W'(1);
                            shiftReg <= shiftNext;
                            tx       <= shiftNext[0];
                        end
                    end else begin
                        bitTimer <= bitTimer + TIMER_W'(1);
                    end
                end

                STOP: begin
                    if (bitDone) begin
                        bitTimer <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        bitTimer <= bitTimer + TIMER_W'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    bitTimer <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: directed frame table, corner-case sequences and a
// randomized run against a cycle-timeline model of the line.
module tb_uart_tx_drain;
    localparam int CLK_DIV    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int FRAME      = (DATA_WIDTH + 2) * CLK_DIV;
    localparam int MAXC       = 3000;

    logic clk = 1'b0;
    logic rst;
    logic tx;
    logic busy;

    uart_tx_drain_if #(.DATA_WIDTH(DATA_WIDTH)) fifo ();

    uart_tx_drain #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .fifo (fifo),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] expFrame;  // bit0 = start bit, bit9 = stop bit
        bit         more;      // another word follows back-to-back
        bit         junk;      // hold fifoReadAck high outside WAIT_ACK
    } vec_t;

    vec_t vecs[6];
    bit   reqPending = 1'b0;

    // Timeline model for the random run
    bit expTx[MAXC+64];
    bit expBusy[MAXC+64];
    bit expReqAt[MAXC+64];
    bit emptyAt[MAXC+64];
    logic [DATA_WIDTH-1:0] q[$];

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReq(input string name, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = fifo.fifoReadReq;
        end
        chk({name, "_req_seen"}, seen, 1'b1);
    endtask

    function automatic logic frameBit(input logic [DATA_WIDTH-1:0] w, input int i);
        int slot;
        slot = i / CLK_DIV;
        if (slot == 0) return 1'b0;
        if (slot <= DATA_WIDTH) return w[slot-1];
        return 1'b1;
    endfunction

    task automatic sendFrame(input vec_t v, input string name);
        bit seen;
        if (!reqPending) begin
            fifo.fifoEmpty   = 1'b0;
            fifo.fifoReadAck = v.junk;
            fifo.fifoData    = ~v.data;
            waitReq(name, seen);
            if (!seen) return;
        end
        reqPending = 1'b0;
        fifo.fifoReadAck = v.junk;
        fifo.fifoData    = ~v.data;
        tick();
        chk({name, "_single_pulse"}, fifo.fifoReadReq, 1'b0);
        chk({name, "_waitack_tx"}, tx, 1'b1);
        chk({name, "_waitack_busy"}, busy, 1'b1);
        fifo.fifoReadAck = 1'b1;
        fifo.fifoData    = v.data;
        fifo.fifoEmpty   = !v.more;
        tick();
        for (int i = 0; i < FRAME; i++) begin
            fifo.fifoReadAck = v.junk;
            fifo.fifoData    = DATA_WIDTH'($urandom);
            chk({name, "_tx"}, tx, v.expFrame[i / CLK_DIV]);
            chk({name, "_busy"}, busy, 1'b1);
            chk({name, "_noreq"}, fifo.fifoReadReq, 1'b0);
            tick();
        end
        fifo.fifoReadAck = 1'b0;
        chk({name, "_idle_tx"}, tx, 1'b1);
        chk({name, "_idle_busy"}, busy, 1'b0);
        chk({name, "_idle_req"}, fifo.fifoReadReq, 1'b0);
        if (v.more) begin
            tick();
            chk({name, "_gap_req"}, fifo.fifoReadReq, 1'b1);
            chk({name, "_gap_tx"}, tx, 1'b1);
            reqPending = 1'b1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   seen;
        bit   anyBad;
        vec_t v;

        vecs[0] = '{8'h55, 10'h2AA, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 10'h200, 1'b1, 1'b1};
        vecs[2] = '{8'hFF, 10'h3FE, 1'b0, 1'b0};
        vecs[3] = '{8'hA5, 10'h34A, 1'b0, 1'b1};
        vecs[4] = '{8'h01, 10'h202, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 10'h300, 1'b0, 1'b1};

        rst              = 1'b1;
        fifo.fifoEmpty   = 1'b1;
        fifo.fifoReadAck = 1'b0;
        fifo.fifoData    = '0;
        tick();
        tick();
        chk("reset_tx", tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_req", fifo.fifoReadReq, 1'b0);
        rst = 1'b0;

        // Empty FIFO for 100 cycles: line must stay idle
        anyBad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (fifo.fifoReadReq || !tx || busy) anyBad = 1'b1;
        end
        chk("idle100_quiet", anyBad, 1'b0);

        for (int i = 0; i < 6; i++) sendFrame(vecs[i], $sformatf("vec%0d", i));

        // Ack withheld with FIFO still non-empty: back to IDLE, immediate retry
        fifo.fifoEmpty = 1'b0;
        waitReq("drop1", seen);
        tick();
        fifo.fifoReadAck = 1'b0;
        tick();
        chk("drop1_tx", tx, 1'b1);
        chk("drop1_busy", busy, 1'b0);
        chk("drop1_req", fifo.fifoReadReq, 1'b0);
        tick();
        chk("drop1_retry", fifo.fifoReadReq, 1'b1);
        // Ack withheld and FIFO now empty: no further retries
        tick();
        fifo.fifoEmpty = 1'b1;
        tick();
        chk("drop2_busy", busy, 1'b0);
        anyBad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fifo.fifoReadReq || !tx) anyBad = 1'b1;
        end
        chk("drop2_noretry", anyBad, 1'b0);
        v = '{8'h3C, 10'h278, 1'b0, 1'b0};
        sendFrame(v, "after_drop");

        // Reset in the middle of data bit 3 of 0xA5
        fifo.fifoEmpty = 1'b0;
        waitReq("rstmid", seen);
        tick();
        fifo.fifoReadAck = 1'b1;
        fifo.fifoData    = 8'hA5;
        fifo.fifoEmpty   = 1'b1;
        tick();
        fifo.fifoReadAck = 1'b0;
        for (int i = 0; i < 4 * CLK_DIV + 1; i++) tick();
        chk("rstmid_bit3", tx, 1'b0);
        rst              = 1'b1;
        fifo.fifoReadAck = 1'b1;
        tick();
        rst              = 1'b0;
        fifo.fifoReadAck = 1'b0;
        chk("rstmid_tx", tx, 1'b1);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_req", fifo.fifoReadReq, 1'b0);
        anyBad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!tx || busy) anyBad = 1'b1;
        end
        chk("rstmid_noresume", anyBad, 1'b0);
        sendFrame(vecs[3], "rstmid_fresh");

        // Reset wins over an ack arriving in WAIT_ACK
        fifo.fifoEmpty = 1'b0;
        waitReq("rstack", seen);
        tick();
        fifo.fifoReadAck = 1'b1;
        fifo.fifoData    = 8'h00;
        rst              = 1'b1;
        tick();
        rst              = 1'b0;
        fifo.fifoReadAck = 1'b0;
        fifo.fifoEmpty   = 1'b1;
        chk("rstack_busy", busy, 1'b0);
        anyBad = 1'b0;
        for (int i = 0; i < FRAME + 5; i++) begin
            tick();
            if (!tx) anyBad = 1'b1;
        end
        chk("rstack_noframe", anyBad, 1'b0);

        // Randomized run against the timeline model
        for (int i = 0; i < MAXC + 64; i++) begin
            expTx[i]    = 1'b1;
            expBusy[i]  = 1'b0;
            expReqAt[i] = 1'b0;
            emptyAt[i]  = 1'b1;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < MAXC; c++) begin
            if (c > 0) tick();
            if (c > 0 && !expBusy[c-1] && !emptyAt[c-1]) begin
                expReqAt[c]  = 1'b1;
                expBusy[c]   = 1'b1;
                expBusy[c+1] = 1'b1;
            end
            chk("rnd_req", fifo.fifoReadReq, expReqAt[c]);
            chk("rnd_tx", tx, expTx[c]);
            chk("rnd_busy", busy, expBusy[c]);
            if (c > 0 && expReqAt[c-1]) begin
                if (q.size() > 0 && $urandom_range(7) != 0) begin
                    logic [DATA_WIDTH-1:0] w;
                    w                = q.pop_front();
                    fifo.fifoReadAck = 1'b1;
                    fifo.fifoData    = w;
                    for (int i = 0; i < FRAME; i++) begin
                        expTx[c+1+i]   = frameBit(w, i);
                        expBusy[c+1+i] = 1'b1;
                    end
                end else begin
                    fifo.fifoReadAck = 1'b0;
                    fifo.fifoData    = DATA_WIDTH'($urandom);
                end
            end else begin
                fifo.fifoReadAck = ($urandom_range(3) == 0);
                fifo.fifoData    = DATA_WIDTH'($urandom);
            end
            if (c < MAXC - 100 && q.size() < 6 && $urandom_range(39) == 0)
                q.push_back(DATA_WIDTH'($urandom));
            fifo.fifoEmpty = (q.size() == 0);
            emptyAt[c]     = fifo.fifoEmpty;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
